// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding and 2 ms timing constants at 50 MHz.
package ps2_pkg;

  localparam int PS2_CLOCK_CYCLES_FOR_2MS   = 100000;
  localparam int PS2_NUMBER_OF_BITS_FOR_2MS = 17;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP   = 3'd3,
    ST_CHECK  = 3'd4
  } ps2_rx_state_t;

endpackage

// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (negedge with data 0)
//   ST_DATA   | shifting in d0..d7
//   ST_PARITY | waiting for the parity bit
//   ST_STOP   | waiting for the stop bit
//   ST_CHECK  | one cycle: validate frame and issue result pulse
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int CLOCK_CYCLES_FOR_2MS   = PS2_CLOCK_CYCLES_FOR_2MS,
  parameter int NUMBER_OF_BITS_FOR_2MS = PS2_NUMBER_OF_BITS_FOR_2MS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       receive_enable,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  output logic [7:0] received_data,
  output logic       received_data_en,
  output logic       parity_error,
  output logic       framing_error,
  output logic       timeout_error
);

  localparam logic [NUMBER_OF_BITS_FOR_2MS-1:0] TIMEOUT_LIMIT =
    NUMBER_OF_BITS_FOR_2MS'(CLOCK_CYCLES_FOR_2MS);

  ps2_rx_state_t state, state_next;

  logic [3:0]                        bit_count, bit_count_next;
  logic [7:0]                        shift_reg, shift_reg_next;
  logic                              parity_bit, parity_bit_next;
  logic                              stop_bit, stop_bit_next;
  logic [NUMBER_OF_BITS_FOR_2MS-1:0] timeout_cnt, timeout_cnt_next;
  logic [7:0]                        received_data_next;
  logic                              received_data_en_next;
  logic                              parity_error_next;
  logic                              framing_error_next;
  logic                              timeout_error_next;
  logic                              timeout_hit;

  assign timeout_hit = (timeout_cnt == TIMEOUT_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      bit_count        <= '0;
      shift_reg        <= '0;
      parity_bit       <= 1'b0;
      stop_bit         <= 1'b0;
      timeout_cnt      <= '0;
      received_data    <= 8'h00;
      received_data_en <= 1'b0;
      parity_error     <= 1'b0;
      framing_error    <= 1'b0;
      timeout_error    <= 1'b0;
    end else begin
      state            <= state_next;
      bit_count        <= bit_count_next;
      shift_reg        <= shift_reg_next;
      parity_bit       <= parity_bit_next;
      stop_bit         <= stop_bit_next;
      timeout_cnt      <= timeout_cnt_next;
      received_data    <= received_data_next;
      received_data_en <= received_data_en_next;
      parity_error     <= parity_error_next;
      framing_error    <= framing_error_next;
      timeout_error    <= timeout_error_next;
    end
  end

  always_comb begin
    state_next            = state;
    bit_count_next        = bit_count;
    shift_reg_next        = shift_reg;
    parity_bit_next       = parity_bit;
    stop_bit_next         = stop_bit;
    timeout_cnt_next      = timeout_cnt;
    received_data_next    = received_data;
    received_data_en_next = 1'b0;
    parity_error_next     = 1'b0;
    framing_error_next    = 1'b0;
    timeout_error_next    = 1'b0;

    case (state)
      ST_IDLE: begin
        bit_count_next   = '0;
        timeout_cnt_next = '0;
        if (receive_enable && ps2_clk_negedge && !ps2_data)
          state_next = ST_DATA;
      end

      // In-frame priority: host takeover, then a bit edge, then timeout.
      ST_DATA: begin
        if (!receive_enable) begin
          state_next = ST_IDLE;
        end else if (ps2_clk_negedge) begin
          timeout_cnt_next              = '0;
          shift_reg_next[bit_count[2:0]] = ps2_data;
          bit_count_next                = bit_count + 4'd1;
          if (bit_count == 4'd7)
            state_next = ST_PARITY;
        end else if (timeout_hit) begin
          timeout_error_next = 1'b1;
          state_next         = ST_IDLE;
        end else begin
          timeout_cnt_next = timeout_cnt + 1'b1;
        end
      end

      ST_PARITY: begin
        if (!receive_enable) begin
          state_next = ST_IDLE;
        end else if (ps2_clk_negedge) begin
          timeout_cnt_next = '0;
          parity_bit_next  = ps2_data;
          state_next       = ST_STOP;
        end else if (timeout_hit) begin
          timeout_error_next = 1'b1;
          state_next         = ST_IDLE;
        end else begin
          timeout_cnt_next = timeout_cnt + 1'b1;
        end
      end

      ST_STOP: begin
        if (!receive_enable) begin
          state_next = ST_IDLE;
        end else if (ps2_clk_negedge) begin
          timeout_cnt_next = '0;
          stop_bit_next    = ps2_data;
          state_next       = ST_CHECK;
        end else if (timeout_hit) begin
          timeout_error_next = 1'b1;
          state_next         = ST_IDLE;
        end else begin
          timeout_cnt_next = timeout_cnt + 1'b1;
        end
      end

      ST_CHECK: begin
        timeout_cnt_next = '0;
        state_next       = ST_IDLE;
        if (!stop_bit) begin
          framing_error_next = 1'b1;
        end else if (^{shift_reg, parity_bit} == 1'b0) begin
          parity_error_next = 1'b1;
        end else begin
          received_data_next    = shift_reg;
          received_data_en_next = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ps2_frame_receiver.md
PS2_FRAME_RECEIVER -- requirements
Module: ps2_frame_receiver

Interface
REQ-001 Parameter CLOCK_CYCLES_FOR_2MS, default 100000; inter-edge timeout in clk cycles, 2 ms at 50 MHz.
REQ-002 Parameter NUMBER_OF_BITS_FOR_2MS, default 17; width of the timeout counter.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 receive_enable  input  1  level; 1 = device-to-host reception allowed (0 while host transmits a command).
REQ-006 ps2_clk_negedge  input  1  one-clk pulse per synchronized PS2_CLK falling edge.
REQ-007 ps2_data  input  1  synchronized PS2_DAT level.
REQ-008 received_data  output  8  last good byte; holds until next good frame.
REQ-009 received_data_en  output  1  one-cycle pulse when received_data updates.
REQ-010 parity_error  output  1  one-cycle pulse: frame rejected, odd parity failed.
REQ-011 framing_error  output  1  one-cycle pulse: frame rejected, stop bit 0.
REQ-012 timeout_error  output  1  one-cycle pulse: frame abandoned, inter-edge timeout.

Function
REQ-013 Frame: start(0), d0..d7 LSB first, odd parity, stop(1); every bit sampled only on a cycle with ps2_clk_negedge=1.
REQ-014 States: IDLE, DATA, PARITY, STOP, CHECK.
REQ-015 IDLE->DATA when receive_enable=1, ps2_clk_negedge=1 and ps2_data=0; otherwise stay IDLE, including when a negedge samples ps2_data=1.
REQ-016 DATA: each negedge shifts ps2_data into shift register bit position bit_count, then increments bit_count (4-bit, 0..7). A negedge at bit_count=7 moves to PARITY.
REQ-017 PARITY: next negedge latches the parity bit and moves to STOP.
REQ-018 STOP: next negedge latches the stop bit and moves to CHECK.
REQ-019 CHECK lasts exactly one cycle, then IDLE; checks in priority order:
- stop=0: framing_error pulse.
- XOR of 8 data bits and parity bit = 0: parity_error pulse.
- Otherwise: received_data loaded and received_data_en pulsed in the same cycle.
REQ-020 Latency: outputs are visible on the clk edge after the cycle that registered the stop-bit negedge (state=CHECK).
REQ-021 Timeout counter: cleared in IDLE/CHECK and on every negedge in DATA/PARITY/STOP; otherwise increments, saturating at CLOCK_CYCLES_FOR_2MS.
REQ-022 Counter equal to CLOCK_CYCLES_FOR_2MS while in DATA/PARITY/STOP: timeout_error pulse next cycle, go IDLE, received_data unchanged.
REQ-023 Negedge and timeout in the same cycle: the negedge wins; counter clears and the state advances.
REQ-024 receive_enable=0 in any state other than IDLE/CHECK: go IDLE next cycle; no output pulse, no error.
REQ-025 At most one of received_data_en/parity_error/framing_error/timeout_error is high in any cycle.

Reset
REQ-026 Reset forces IDLE; bit_count, shift register, and timeout counter = 0; received_data=8'h00; all pulse outputs = 0.
REQ-027 Reset mid-frame discards the partial frame with no pulse; reception resumes with the next start bit after reset release.

Structure
REQ-028 Shared package ps2_pkg holds the state enumeration (3-bit) and the 2 ms/50 MHz timing constants, shared with the command transmitter.
REQ-029 Single module; no sub-module. Timeout counter and shift register inline; all outputs registered.

Verification
REQ-030 Frame 0x1C, parity 0, stop 1, enable=1 -> received_data=8'h1C, received_data_en one cycle, no errors.
REQ-031 Frame 0xAA with parity 0 -> parity_error one pulse; received_data keeps prior 8'h1C; no received_data_en.
REQ-032 Frame 0xF0, parity 1, stop 0 -> framing_error one pulse only; received_data unchanged.
REQ-033 Start plus 4 data bits, then clock stops -> timeout_error exactly 100000 cycles after the last negedge (+1 registering cycle); state IDLE; a following 0x55 frame (parity 1) is received correctly.
REQ-034 receive_enable=0 during a full 0x1C frame -> no pulses; drop enable after bit 3 of a frame -> IDLE, no pulses; reset asserted mid-frame -> all outputs 0, next frame good.
